// File: rtl/sonar_bus_pkg.sv
// Shared definitions for the sonar register-bus initiator: bus width,
// register map, FSM encoding and the command record.
package sonar_bus_pkg;

  localparam int BUS_WIDTH = 16;
  localparam int ADR_WIDTH = 4;

  // Register map of the sonar datapath slave
  localparam logic [ADR_WIDTH-1:0] CONTROL   = 4'd0;
  localparam logic [ADR_WIDTH-1:0] A0        = 4'd1;
  localparam logic [ADR_WIDTH-1:0] A1        = 4'd2;
  localparam logic [ADR_WIDTH-1:0] A2        = 4'd3;
  localparam logic [ADR_WIDTH-1:0] B1        = 4'd4;
  localparam logic [ADR_WIDTH-1:0] B2        = 4'd5;
  localparam logic [ADR_WIDTH-1:0] AMP       = 4'd6;
  localparam logic [ADR_WIDTH-1:0] THRESHOLD = 4'd7;
  localparam logic [ADR_WIDTH-1:0] TIMER     = 4'd8;
  localparam logic [ADR_WIDTH-1:0] PCM       = 4'd9;
  localparam logic [ADR_WIDTH-1:0] PCM_LOAD  = 4'd10;
  localparam logic [ADR_WIDTH-1:0] FB0       = 4'd11;
  localparam logic [ADR_WIDTH-1:0] FB1       = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [BUS_WIDTH-1:0] dat;
  } cmd_t;

endpackage

// File: rtl/sonar_cmd_fifo.sv
// Synchronous command FIFO with occupancy count. The caller guarantees
// push only when not full and pop only when non-empty.
module sonar_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sonar_bus_master.sv
// Register-bus initiator: queues host commands and runs them one at a time
// on the single-cycle-strobe register bus, returning data or a timeout error.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are
// both high. valid, once raised, holds with a stable payload until the
// transfer; ready may change freely and does not depend on valid.
module sonar_bus_master
  import sonar_bus_pkg::*;
#(
  parameter int BUS_WIDTH  = sonar_bus_pkg::BUS_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [3:0]           cmd_adr_i,
  input  logic [BUS_WIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_we_o,
  output logic [BUS_WIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wb_valid_o,
  output logic [3:0]           wbs_adr_o,
  output logic [BUS_WIDTH-1:0] wbs_dat_o,
  output logic                 wbs_strb_o,
  input  logic                 wbs_ack_i,
  input  logic [BUS_WIDTH-1:0] wbs_dat_i,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o,
  output state_t               dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 1 + 4 + BUS_WIDTH;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;
  logic            take_ack;
  logic            take_tmo;
  logic            bus_we;
  logic [7:0]      tmo_cnt;

  assign cmd_ready_o = (count != CW'(FIFO_DEPTH));
  assign push        = cmd_valid_i & cmd_ready_o;
  assign busy_o      = (state != IDLE) | (count != '0);
  // The strobe lives only in ISSUE, which always lasts exactly one cycle
  assign wb_valid_o  = (state == ISSUE);
  assign wbs_strb_o  = (state == ISSUE) & bus_we;
  assign rsp_valid_o = (state == RESP);
  assign dbg_state_o = state;

  sonar_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data ({cmd_we_i, cmd_adr_i, cmd_dat_i}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    take_ack   = 1'b0;
    take_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (wbs_ack_i) begin
          take_ack   = 1'b1;
          state_next = RESP;
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          take_tmo   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus command latch, timeout counter, response payload and error count
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_we    <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      tmo_cnt   <= '0;
      rsp_we_o  <= 1'b0;
      rsp_err_o <= 1'b0;
      rsp_dat_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (pop) {bus_we, wbs_adr_o, wbs_dat_o} <= head;

      if (state == ISSUE)
        tmo_cnt <= '0;
      else if (state == WAIT && !take_ack && !take_tmo)
        tmo_cnt <= tmo_cnt + 8'd1;

      if (take_ack) begin
        rsp_we_o  <= bus_we;
        rsp_err_o <= 1'b0;
        rsp_dat_o <= bus_we ? '0 : wbs_dat_i;
      end else if (take_tmo) begin
        rsp_we_o  <= bus_we;
        rsp_err_o <= 1'b1;
        rsp_dat_o <= '0;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sonar_bus_master.sv
// Bench for sonar_bus_master: slave model, transaction-level reference
// model with expected queues, a per-cycle monitor and directed scenarios.
module tb_sonar_bus_master;
  import sonar_bus_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_adr_i;
  logic [15:0] cmd_dat_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
  logic [15:0] rsp_dat_o;
  logic        wb_valid_o, wbs_strb_o, wbs_ack_i, busy_o;
  logic [3:0]  wbs_adr_o;
  logic [15:0] wbs_dat_o, wbs_dat_i;
  logic [7:0]  err_cnt_o;
  state_t      dbg_state;

  always #5 clk = ~clk;

  sonar_bus_master #(.BUS_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wb_valid_o(wb_valid_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_strb_o(wbs_strb_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o), .dbg_state_o(dbg_state)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // A transaction's result is fully decided when it is accepted, because
  // the initiator runs commands strictly in order, one at a time.
  logic [15:0] model_mem [16];
  int          model_err = 0;
  logic [20:0] iss_q[$];   // {we, adr, dat} expected on the bus
  logic [17:0] exp_q[$];   // {we, err, dat} expected on the response
  logic [7:0]  errc_q[$];  // err_cnt_o expected with each response

  task automatic model_accept(input cmd_t c);
    logic [17:0] r;
    iss_q.push_back(c);
    if (c.adr >= 4'd13) begin
      r = {c.we, 1'b1, 16'h0000};
      if (model_err != 255) model_err++;
    end else if (c.we) begin
      r = {1'b1, 1'b0, 16'h0000};
      model_mem[c.adr] = c.dat;
    end else begin
      r = {1'b0, 1'b0, model_mem[c.adr]};
    end
    exp_q.push_back(r);
    errc_q.push_back(8'(model_err));
  endtask

  // ---------------- slave model ----------------
  // Addresses 0..12 ack one cycle after the strobe; 13..15 never ack,
  // except that late_ack_en injects a stray ack long after the strobe.
  logic [15:0] slave_mem [16];
  logic        late_ack_en = 1'b0;

  initial begin
    logic [3:0]  s_adr;
    logic        s_we;
    logic [15:0] s_dat;
    for (int i = 0; i < 16; i++) slave_mem[i] = 16'h1000 + 16'(i);
    wbs_ack_i = 1'b0;
    wbs_dat_i = 16'h0000;
    forever begin
      @(negedge clk);
      if (wb_valid_o && !wb_rst_i) begin
        s_adr = wbs_adr_o;
        s_we  = wbs_strb_o;
        s_dat = wbs_dat_o;
        if (s_adr < 4'd13) begin
          if (s_we) slave_mem[s_adr] = s_dat;
          @(posedge clk); #1;
          wbs_ack_i = 1'b1;
          wbs_dat_i = s_we ? 16'hDEAD : slave_mem[s_adr];
          @(posedge clk); #1;
          wbs_ack_i = 1'b0;
          wbs_dat_i = 16'h0000;
        end else if (late_ack_en) begin
          repeat (20) @(posedge clk);
          #1;
          wbs_ack_i = 1'b1;
          wbs_dat_i = 16'hBEEF;
          @(posedge clk); #1;
          wbs_ack_i = 1'b0;
          wbs_dat_i = 16'h0000;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          n_strobes = 0;
  int          strb_cyc[$];
  logic        prev_valid = 1'b0;
  logic        hold_valid = 1'b0;
  logic [17:0] hold_val;

  initial forever begin
    logic [20:0] e;
    logic [17:0] got;
    @(negedge clk);
    if (!wb_rst_i) begin
      if (wb_valid_o) begin
        n_strobes++;
        strb_cyc.push_back(cyc);
        check("single_cycle_valid", 32'(prev_valid), 32'd0);
        if (iss_q.size() == 0) fail_now("unexpected_strobe");
        else begin
          e = iss_q.pop_front();
          check("bus_adr", 32'(wbs_adr_o), 32'(e[19:16]));
          check("bus_strb", 32'(wbs_strb_o), 32'(e[20]));
          if (e[20]) check("bus_dat", 32'(wbs_dat_o), 32'(e[15:0]));
        end
      end
      got = {rsp_we_o, rsp_err_o, rsp_dat_o};
      if (rsp_valid_o) begin
        if (hold_valid) check("rsp_stable", 32'(got), 32'(hold_val));
        if (rsp_ready_i) begin
          hold_valid = 1'b0;
          if (exp_q.size() == 0) fail_now("unexpected_rsp");
          else begin
            check("rsp_payload", 32'(got), 32'(exp_q.pop_front()));
            check("rsp_err_cnt", 32'(err_cnt_o), 32'(errc_q.pop_front()));
          end
        end else begin
          hold_valid = 1'b1;
          hold_val   = got;
        end
      end else hold_valid = 1'b0;
    end else hold_valid = 1'b0;
    prev_valid = wb_valid_o;
  end

  // ---------------- driver tasks ----------------
  function automatic cmd_t mk(input logic we, input logic [3:0] adr, input logic [15:0] dat);
    cmd_t c;
    c.we  = we;
    c.adr = adr;
    c.dat = dat;
    return c;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input cmd_t c, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = c.we;
    cmd_adr_i   = c.adr;
    cmd_dat_i   = c.dat;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = cmd_ready_o;
      if (!acc) waits++;
      @(posedge clk); #1;
    end
    cmd_valid_i = 1'b0;
    if (acc) model_accept(c);
    else fail_now("cmd_accept_timeout");
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Returns at the falling edge where rsp_valid_o is first seen.
  task automatic wait_rsp(output int at);
    logic seen;
    seen = 1'b0;
    at = -1;
    for (int b = 0; b < 100 && !seen; b++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) fail_now("rsp_wait_timeout");
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int b = 0; b < budget && !done; b++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid_o) done = 1'b1;
    end
    if (!done) fail_now("drain_timeout");
    sync();
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  initial begin
    #2000000;
    fail_now("watchdog_expired");
    finish_run();
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w, wsum, k, at, n0;
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h1000 + 16'(i);
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 4'd0; cmd_dat_i = 16'h0;
    rsp_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_outputs", 32'({rsp_valid_o, rsp_we_o, rsp_err_o, wb_valid_o, wbs_strb_o, busy_o}), 32'd0);
    check("rst_data", 32'({rsp_dat_o, wbs_dat_o}), 32'd0);
    check("rst_adr_errcnt", 32'({wbs_adr_o, err_cnt_o}), 32'd0);
    sync();
    wb_rst_i = 1'b0;
    sync();

    // Write AMP then read it back
    n0 = n_strobes;
    send(mk(1'b1, AMP, 16'h0003), w);
    k = cyc;
    wait_rsp(at);
    check("first_rsp_latency", 32'(at - k), 32'd3);
    check("write_rsp", 32'({rsp_we_o, rsp_err_o, rsp_dat_o}), 32'h20000);
    sync();
    send(mk(1'b0, AMP, 16'h0000), w);
    wait_rsp(at);
    check("amp_readback", 32'({rsp_we_o, rsp_err_o, rsp_dat_o}), 32'h00003);
    wait_drain(50);
    check("one_strobe_per_txn", 32'(n_strobes - n0), 32'd2);

    // Five back-to-back commands into a depth-4 FIFO
    strb_cyc.delete();
    wsum = 0;
    send(mk(1'b1, A0, 16'h1111), w);  wsum += w;
    send(mk(1'b0, A0, 16'h0000), w);  wsum += w;
    send(mk(1'b1, A1, 16'h2222), w);  wsum += w;
    send(mk(1'b0, AMP, 16'h0000), w); wsum += w;
    send(mk(1'b0, A1, 16'h0000), w);  wsum += w;
    check("no_backpressure_before_full", 32'(wsum), 32'd0);
    @(negedge clk);
    check("ready_low_when_full", 32'(cmd_ready_o), 32'd0);
    wait_drain(100);
    check("five_strobes", 32'(strb_cyc.size()), 32'd5);
    for (int i = 1; i < strb_cyc.size(); i++)
      check("strobe_spacing", 32'(strb_cyc[i] - strb_cyc[i-1]), 32'd4);

    // Timeout on a non-acking address, followed by a stray late ack
    late_ack_en = 1'b1;
    n0 = n_strobes;
    send(mk(1'b0, 4'd13, 16'h0000), w);
    k = cyc;
    wait_rsp(at);
    check("timeout_latency", 32'(at - k), 32'd17);
    check("timeout_rsp", 32'({rsp_we_o, rsp_err_o, rsp_dat_o}), 32'h10000);
    check("timeout_err_cnt", 32'(err_cnt_o), 32'd1);
    sync();
    repeat (30) @(posedge clk);
    #1;
    check("late_ack_ignored", 32'({busy_o, err_cnt_o}), 32'd1);
    check("late_ack_no_strobe", 32'(n_strobes - n0), 32'd1);
    late_ack_en = 1'b0;

    // Response backpressure with two commands queued
    rsp_ready_i = 1'b0;
    n0 = n_strobes;
    send(mk(1'b1, B1, 16'h0055), w);
    send(mk(1'b0, B1, 16'h0000), w);
    wait_rsp(at);
    repeat (10) @(posedge clk);
    #1;
    check("no_issue_while_blocked", 32'(n_strobes - n0), 32'd1);
    rsp_ready_i = 1'b1;
    wait_drain(50);
    check("issue_after_release", 32'(n_strobes - n0), 32'd2);

    // Reset while waiting on the bus with three commands queued
    send(mk(1'b0, 4'd13, 16'h0000), w);
    send(mk(1'b0, A0, 16'h0000), w);
    send(mk(1'b0, A1, 16'h0000), w);
    send(mk(1'b0, CONTROL, 16'h0000), w);
    check("in_wait_before_reset", 32'(dbg_state), 32'(WAIT));
    wb_rst_i = 1'b1;
    iss_q.delete(); exp_q.delete(); errc_q.delete();
    model_err = 0;
    sync();
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    check("mid_rst_outputs", 32'({rsp_valid_o, rsp_we_o, rsp_err_o, wb_valid_o, wbs_strb_o, busy_o}), 32'd0);
    check("mid_rst_errcnt", 32'(err_cnt_o), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    n0 = n_strobes;
    repeat (30) @(posedge clk);
    #1;
    check("queue_lost_after_rst", 32'(n_strobes - n0), 32'd0);
    send(mk(1'b0, AMP, 16'h0000), w);
    wait_drain(50);

    // 256 timeouts saturate the error counter
    for (int i = 0; i < 256; i++) send(mk(1'b0, 4'd14, 16'h0000), w);
    wait_drain(200);
    check("err_cnt_saturated", 32'(err_cnt_o), 32'd255);
    check("queues_empty", 32'(iss_q.size() + exp_q.size()), 32'd0);

    finish_run();
  end

endmodule
